mc_ctrl: RTL

Multi-cycle control unit for the MIPS core, replacing the purely combinational funct-to-ALU decoder of the single-cycle datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states and handshakes with a shared instruction/data memory that may insert wait states. Decodes R-type and a subset of I-type instructions into a parametrised one-hot ALU control word. Flags unsupported encodings instead of holding a stale ALU code.

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_alu_dec.sv | 63 ++++++
 rtl/mc_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states,
// instruction field encodings, ALU one-hot bit positions, ALU B-source codes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_XOR  = 6'b100110;

    // Bit positions inside the one-hot ALU control word
    localparam int ALU_ADDU = 0;
    localparam int ALU_SUBU = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_AND  = 3;
    localparam int ALU_OR   = 4;
    localparam int ALU_SLT  = 5;
    localparam int ALU_SLTU = 6;
    localparam int ALU_XOR  = 7;

    // ALU B-operand source select
    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_SEXT = 2'd1;
    localparam logic [1:0] SRC_B_ZEXT = 2'd2;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decoder: opcode/funct to one-hot ALU control,
// B-operand source and an illegal-encoding flag. ALU_W is 6 or 8; the two
// extra ops (sltu, xor) only exist in the 8-wide variant.
module mc_alu_dec
    import mc_pkg::*;
#(
    parameter int ALU_W = 8
) (
    input  logic [31:0]      instr,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic [1:0]       alu_src_b,
    output logic             illegal
);

    localparam bit EXT = (ALU_W == 8);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [7:0] onehot;
    logic       unused_bits;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Register fields and (for ALU_W = 6) the top one-hot bits are not decoded here.
    assign unused_bits = ^{instr[25:6], onehot};

    // Decode table; anything not listed is illegal and drives a zero ALU word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        onehot    = '0;
        alu_src_b = SRC_B_RT;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: onehot[ALU_ADDU] = 1'b1;
                    FN_SUBU: onehot[ALU_SUBU] = 1'b1;
                    FN_ADD:  onehot[ALU_ADD]  = 1'b1;
                    FN_AND:  onehot[ALU_AND]  = 1'b1;
                    FN_OR:   onehot[ALU_OR]   = 1'b1;
                    FN_SLT:  onehot[ALU_SLT]  = 1'b1;
                    FN_SLTU: if (EXT) onehot[ALU_SLTU] = 1'b1; else illegal = 1'b1;
                    FN_XOR:  if (EXT) onehot[ALU_XOR]  = 1'b1; else illegal = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_ADDIU: begin
                onehot[ALU_ADDU] = 1'b1;
                alu_src_b        = SRC_B_SEXT;
            end
            OP_ORI: begin
                onehot[ALU_OR] = 1'b1;
                alu_src_b      = SRC_B_ZEXT;
            end
            OP_BEQ: onehot[ALU_SUBU] = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign alu_ctrl = onehot[ALU_W-1:0];

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB plus a sticky TRAP for
// illegal encodings. Decode results are captured at the end of DECODE and
// only presented to the datapath in EXEC/MEM/WB. A 'run' flag keeps every
// output low until the first clock edge after reset release.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int ALU_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_b,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             illegal
);

    state_t           state, state_n;
    logic             run;
    logic [ALU_W-1:0] alu_q;
    logic [1:0]       src_q;
    logic [5:0]       op_q;
    logic [ALU_W-1:0] dec_alu;
    logic [1:0]       dec_src;
    logic             dec_illegal;

    mc_alu_dec #(.ALU_W(ALU_W)) u_dec (
        .instr     (instr),
        .alu_ctrl  (dec_alu),
        .alu_src_b (dec_src),
        .illegal   (dec_illegal)
    );

    // State register and the post-reset run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= S_FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_n;
            run   <= 1'b1;
        end
    end

    // Capture the decode of the instruction register at the end of DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these small decode registers are reset so they never hold X, even though outputs are gated by state.
        if (!rst_n) begin
            alu_q <= '0;
            src_q <= SRC_B_RT;
            op_q  <= '0;
        end else if (state == S_DECODE) begin
            alu_q <= dec_alu;
            src_q <= dec_src;
            op_q  <= instr[31:26];
        end
    end

    // Next-state and Moore-style outputs; only FETCH/EXEC qualify on inputs.
    always_comb begin
        state_n    = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = SRC_B_RT;
        alu_ctrl   = '0;
        illegal    = 1'b0;
        if (run) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_n = S_DECODE;
                    end
                end
                S_DECODE: state_n = dec_illegal ? S_TRAP : S_EXEC;
                S_EXEC: begin
                    alu_ctrl  = alu_q;
                    alu_src_b = src_q;
                    if (op_q == OP_BEQ) begin
                        pc_we   = alu_zero;
                        pc_src  = 1'b1;
                        state_n = S_FETCH;
                    end else if (op_q == OP_LW || op_q == OP_SW) begin
                        state_n = S_MEM;
                    end else begin
                        state_n = S_WB;
                    end
                end
                S_MEM: begin
                    alu_ctrl  = alu_q;
                    alu_src_b = src_q;
                    mem_req   = 1'b1;
                    mem_we    = (op_q == OP_SW);
                    if (mem_ready) state_n = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
                S_WB: begin
                    alu_ctrl   = alu_q;
                    alu_src_b  = src_q;
                    reg_we     = 1'b1;
                    reg_dst    = (op_q == OP_RTYPE);
                    mem_to_reg = (op_q == OP_LW);
                    state_n    = S_FETCH;
                end
                S_TRAP: illegal = 1'b1;
                default: state_n = S_FETCH;
            endcase
        end
    end

endmodule
